// File: rtl/machine2_stim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : machine2_stim_pkg
//  Description : Shared definitions for the machine2 stimulus/measurement
//                controller: state encoding, path-select codes and the
//                nominal path latencies of the 4-bit control automaton.
//  Revision    : 1.0 - initial release
// ============================================================================
package machine2_stim_pkg;

    // Controller states; CHK is only reachable when the stability check is built in
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_RUN  = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Path-select codes carried on the mode input
    localparam logic [1:0] M_WAIT   = 2'b00;
    localparam logic [1:0] M_LONG0  = 2'b01;
    localparam logic [1:0] M_LONG1  = 2'b10;
    localparam logic [1:0] M_DIRECT = 2'b11;

    // Nominal automaton latencies, in clock edges counted from the first RUN cycle
    localparam int LAT_DIRECT = 4;
    localparam int LAT_LONG   = 6;
    // RUN count at which the wait path is released (before adding hold)
    localparam int WAIT_ENTRY = 3;

    // Number of cycles result must stay high after it rises
    localparam int CHK_CYCLES = 4;

endpackage : machine2_stim_pkg
`default_nettype wire

// File: rtl/stim_cond_dec.sv
`default_nettype none
// ============================================================================
//  Module      : stim_cond_dec
//  Description : Combinational decode of the latched path select, hold and
//                run count into the automaton condition lines x1..x3, plus
//                the expected path latency. Requires CNT_W >= 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module stim_cond_dec
    import machine2_stim_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             active,
    input  logic [1:0]       mode,
    input  logic [3:0]       hold,
    input  logic [CNT_W-1:0] cnt,
    output logic             x1,
    output logic             x2,
    output logic             x3,
    output logic [CNT_W:0]   exp_lat
);

    // One extra bit so hold-extended values never wrap
    logic [CNT_W:0] w_hold_ext;
    logic [CNT_W:0] w_cnt_ext;
    logic [CNT_W:0] w_wait_release;

    assign w_hold_ext     = (CNT_W+1)'(hold);
    assign w_cnt_ext      = {1'b0, cnt};
    assign w_wait_release = (CNT_W+1)'(WAIT_ENTRY) + w_hold_ext;

    // Per-path condition drive; all lines forced low when not steering
    always_comb begin
        x1      = 1'b0;
        x2      = 1'b0;
        x3      = 1'b0;
        exp_lat = (CNT_W+1)'(LAT_LONG);
        case (mode)
            M_WAIT: begin
                // Exit is released hold cycles after the wait state is entered
                x3      = (w_cnt_ext >= w_wait_release);
                exp_lat = (CNT_W+1)'(WAIT_ENTRY + 1) + w_hold_ext;
            end
            M_LONG0: begin
                x2      = 1'b1;
            end
            M_LONG1: begin
                x2      = 1'b1;
                x1      = 1'b1;
            end
            default: begin
                x3      = 1'b1;
                exp_lat = (CNT_W+1)'(LAT_DIRECT);
            end
        endcase
        if (!active) begin
            x1 = 1'b0;
            x2 = 1'b0;
            x3 = 1'b0;
        end
    end

endmodule : stim_cond_dec
`default_nettype wire

// File: rtl/machine2_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : machine2_stim_gen
//  Description : Stimulus/measurement controller for the 4-bit control
//                automaton. Resets it, steers it down a selected path,
//                counts edges until result rises and flags latency errors
//                or timeout.
//                Optional macro STIM_STABLE_CHECK_EN adds a post-rise
//                stability window (CHK state) before the done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module machine2_stim_gen
    import machine2_stim_pkg::*;
#(
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [3:0]       hold,
    input  logic             result,
    output logic             fsm_reset,
    output logic             x1,
    output logic             x2,
    output logic             x3,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] latency,
    output logic             mismatch,
    output logic             timeout_err
);

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_mode;
    logic [3:0]       r_hold;
    logic             w_active;
    logic [CNT_W:0]   w_exp_lat;
    logic             w_lat_bad;
`ifdef STIM_STABLE_CHECK_EN
    logic [1:0]       r_chk;
`endif

    // Condition lines only steer the automaton while it is being measured
    assign w_active  = (r_state == S_RUN) || (r_state == S_CHK);
    assign w_lat_bad = ({1'b0, r_cnt} != w_exp_lat);

    // Automaton held in reset while idle and during the explicit reset cycle
    assign fsm_reset = (r_state == S_IDLE) || (r_state == S_RST);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

    stim_cond_dec #(
        .CNT_W   (CNT_W)
    ) u_cond_dec (
        .active  (w_active),
        .mode    (r_mode),
        .hold    (r_hold),
        .cnt     (r_cnt),
        .x1      (x1),
        .x2      (x2),
        .x3      (x3),
        .exp_lat (w_exp_lat)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only honoured from IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RST;
                end
            end
            S_RST: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                if (result) begin
`ifdef STIM_STABLE_CHECK_EN
                    w_next = S_CHK;
`else
                    w_next = S_DONE;
`endif
                end else if (r_cnt == c_TIMEOUT) begin
                    w_next = S_DONE;
                end
            end
`ifdef STIM_STABLE_CHECK_EN
            S_CHK: begin
                if (r_chk == 2'(CHK_CYCLES - 1)) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Measurement datapath: request latch, edge counter and result flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_mode      <= M_WAIT;
            r_hold      <= '0;
            latency     <= '0;
            mismatch    <= 1'b0;
            timeout_err <= 1'b0;
`ifdef STIM_STABLE_CHECK_EN
            r_chk       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode      <= mode;
                        r_hold      <= hold;
                        latency     <= '0;
                        mismatch    <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                S_RST: begin
                    r_cnt <= '0;
`ifdef STIM_STABLE_CHECK_EN
                    r_chk <= '0;
`endif
                end
                S_RUN: begin
                    if (result) begin
                        latency  <= r_cnt;
                        mismatch <= w_lat_bad;
                    end else if (r_cnt == c_TIMEOUT) begin
                        latency     <= c_TIMEOUT;
                        timeout_err <= 1'b1;
                        mismatch    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef STIM_STABLE_CHECK_EN
                S_CHK: begin
                    // Count is frozen here so the x drive stays unchanged
                    r_chk <= r_chk + 2'd1;
                    if (!result) begin
                        mismatch <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule : machine2_stim_gen
`default_nettype wire

// File: doc/machine2_stim_gen.md
Name: machine2_stim_gen

Overview:
- Stimulus/measurement controller for the 4-bit control automaton (inputs x1/x2/x3, Moore output result). It sits on the other side of that interface.
- On a start command it resets the automaton and drives the condition lines x1..x3 to steer it down one selected path.
- It counts clock edges until result rises, compares the count against the expected path latency, and reports done/latency/error.
- Used in lab self-test tops and as the bench driver for the automaton.

Parameters:
- CNT_W, 5, width of the latency counter and latency output.
- TIMEOUT, 31, RUN-cycle limit before timeout_err (must be < 2^CNT_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (block reset when 0).
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  path select: 00 = wait-then-exit, 01 = x1=0 long path, 10 = x1=1 long path, 11 = direct exit.
- hold  in  4  extra cycles to hold the automaton in its wait state (mode 00 only).
- result  in  1  automaton output.
- fsm_reset  out  1  active-high reset to the automaton.
- x1, x2, x3  out  1 each  condition lines to the automaton.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at end of measurement.
- latency  out  CNT_W  measured edge count, held until the next start.
- mismatch  out  1  latency differs from expected; held until the next start.
- timeout_err  out  1  result never rose; held until the next start.

Behaviour:
- Reset values: state=IDLE, fsm_reset=1, x1=x2=x3=0, busy=0, done=0, latency=0, mismatch=0, timeout_err=0, cnt=0.
- States: IDLE, RST, RUN, (CHK), DONE.
- IDLE: fsm_reset=1, busy=0.
  - On start=1, latch mode/hold, clear latency/mismatch/timeout_err, go to RST.
- RST: one cycle, fsm_reset=1, cnt<=0, then go to RUN.
- RUN: fsm_reset=0. At each edge:
  - If result=1: latency<=cnt; mismatch<=(cnt!=expected); go to CHK if compiled, else DONE.
  - Else if cnt==TIMEOUT: latency<=TIMEOUT; timeout_err<=1; mismatch<=1; go to DONE.
  - Else cnt<=cnt+1.
- Condition lines are a combinational decode of the latched mode and cnt; they are 0 outside RUN/CHK.
  - mode 00: x2=0, x1=0, x3=(cnt>=3+hold).
  - mode 01: x2=1, x1=0, x3=0.
  - mode 10: x2=1, x1=1, x3=0.
  - mode 11: x2=0, x1=0, x3=1.
- Expected latency: mode 11 → 4; modes 01/10 → 6; mode 00 → 4+hold. Computed at CNT_W+1 bits, no wrap.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE (which reasserts fsm_reset).
- start while busy is ignored. start in the DONE cycle is ignored.
- result=1 in the first RUN cycle gives latency=0 and mismatch=1.
- reset=0 at any point: immediate return to the reset values. A measurement in progress is abandoned with no done pulse.

Optional Feature:
- Macro: STIM_STABLE_CHECK_EN.
- Defined: after result rises, enter CHK for 4 cycles, keeping the same x drive.
  - Any cycle with result=0 in CHK sets mismatch=1.
  - Then go to DONE; the done pulse comes 4 cycles later.
- Undefined: no CHK state; RUN goes straight to DONE.

Decomposition:
- Package machine2_stim_pkg:
  - state encoding (IDLE/RST/RUN/CHK/DONE);
  - mode constants M_WAIT=2'b00, M_LONG0=2'b01, M_LONG1=2'b10, M_DIRECT=2'b11;
  - latency constants LAT_DIRECT=4, LAT_LONG=6, WAIT_ENTRY=3.
- Sub-module stim_cond_dec: combinational mode/cnt/hold → x1..x3 and expected latency. The counter and FSM stay in the top.

Test Plan:
- start, mode=11, against the real automaton → x3=1 in RUN; done after 6 clocks from start; latency=4, mismatch=0, timeout_err=0.
- mode=01, then mode=10 → latency=6 both, mismatch=0; x1 matches the mode bit during RUN.
- mode=00, hold=0, then hold=5 → latency=4, then 9; x3 stays 0 through cnt=7 and goes 1 at cnt=8.
- result tied 0, mode=11 → timeout_err=1, mismatch=1, latency=31, done after TIMEOUT+1 RUN cycles.
- reset pulled to 0 mid-RUN (cnt=3), then released → all outputs at reset values, fsm_reset=1, no done; a new start then measures correctly.
- start pulsed while busy and in the DONE cycle → ignored. With STIM_STABLE_CHECK_EN, result forced 0 for one CHK cycle → mismatch=1.
